// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
//
// Shared definitions for the sequential restoring divider:
//   - div_state_t        : FSM state encoding (IDLE / CALC / DONE)
//   - DIV_WIDTH_DEFAULT  : default operand/result width
//   - DIV_WIDTH_MIN/MAX  : legal range for the WIDTH parameter
//   - div_cnt_width()    : width of the step counter for a given WIDTH
// -----------------------------------------------------------------------------
package seq_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;
  localparam int DIV_WIDTH_MIN     = 2;
  localparam int DIV_WIDTH_MAX     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // The step counter must be able to hold values 0..width-1; one spare
  // bit of headroom keeps the arithmetic simple at width = 2^n.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//
// One combinational restoring shift-subtract step.
//   rem_i     [WIDTH:0]   partial remainder before the step
//   divisor_i [WIDTH-1:0] divisor
//   bit_i                 next dividend bit (MSB first)
//   rem_o     [WIDTH:0]   partial remainder after the step
//   q_o                   quotient bit produced by this step
//
// The shifted trial value is WIDTH+2 bits wide so the compare never loses a
// carry; the result always fits back into WIDTH+1 bits because a restored
// remainder is strictly below the divisor (or, for divisor 0, is just the
// dividend prefix seen so far).
// -----------------------------------------------------------------------------
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {2'b00, divisor_i});
  // Only used when q_o is set, in which case the true difference is below
  // the divisor and the dropped top bit is zero.
  assign diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
  assign rem_o   = q_o ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Unsigned sequential divider, one restoring step per clock, MSB first.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   start        request; sampled only in IDLE or DONE
//   dividend     [WIDTH-1:0] numerator, captured when start is accepted
//   divisor      [WIDTH-1:0] denominator, captured when start is accepted
//   busy         high while in CALC
//   done         one-cycle pulse (the DONE cycle) marking new results
//   quotient     [WIDTH-1:0] registered result
//   remainder    [WIDTH-1:0] registered result
//   div_by_zero  registered flag, divisor was 0 for the last result
//   state_o      current FSM state (debug visibility)
//
// Handshake: start is accepted on a rising edge where the FSM is in IDLE or
// DONE and start is high; operands are latched on that same edge. start is
// ignored in CALC. Results change only on entry to DONE, where done is high
// for exactly one cycle; results then hold until the next DONE. Holding
// start high through DONE chains divisions back to back with busy low for
// just the DONE cycle.
//
// Latency: done is high WIDTH cycles after the accepting edge.
//
// Build option SEQ_DIV_ZERO_FAST_EN: a zero divisor is recognised at
// acceptance and the result is produced one cycle later without running the
// WIDTH steps; busy stays low throughout. Without it, a zero divisor runs
// all WIDTH steps, which naturally yields quotient all-ones and
// remainder = dividend.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_t       state_o
);

  localparam int              CNT_W     = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < DIV_WIDTH_MIN || WIDTH > DIV_WIDTH_MAX) begin : g_bad_width
      $error("seq_divider: WIDTH out of supported range");
    end
  endgenerate

  // FSM and registered outputs
  div_state_t       state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_res_q;
  logic [WIDTH-1:0] rem_res_q;
  logic             dbz_q;

  // Datapath: dvd_q starts as the dividend and is shifted left each step;
  // quotient bits enter at the LSB, so after WIDTH steps it holds the
  // quotient. rem_q is the WIDTH+1 bit partial remainder.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef SEQ_DIV_ZERO_FAST_EN
  logic             zfast_q;   // current CALC cycle is a zero-divisor bypass
`endif

  // Next values produced by one restoring step
  logic [WIDTH:0]   step_rem_d;
  logic             step_q;
  logic [WIDTH-1:0] dvd_d;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem_d),
    .q_o       (step_q)
  );

  assign dvd_d = {dvd_q[WIDTH-2:0], step_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
      zfast_q   <= 1'b0;
`endif
    end else begin
      // done is a pulse: only the CALC->DONE transition raises it
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_CALC;
`ifdef SEQ_DIV_ZERO_FAST_EN
            // Zero divisor spends its single CALC cycle with busy low
            zfast_q <= (divisor == '0);
            busy_q  <= (divisor != '0);
`else
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_CALC: begin
`ifdef SEQ_DIV_ZERO_FAST_EN
          if (zfast_q) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            quo_res_q <= '1;
            rem_res_q <= dvd_q;    // still the unshifted dividend
            dbz_q     <= 1'b1;
            zfast_q   <= 1'b0;
          end else begin
`endif
            rem_q <= step_rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              quo_res_q <= dvd_d;
              rem_res_q <= step_rem_d[WIDTH-1:0];
              dbz_q     <= (dvs_q == '0);
            end
`ifdef SEQ_DIV_ZERO_FAST_EN
          end
`endif
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_res_q;
  assign remainder   = rem_res_q;
  assign div_by_zero = dbz_q;
  assign state_o     = state_q;

endmodule
